// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for a single-port data memory (IDLE/ACCESS/RESP FSM).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins every tie.
module mem_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [ADDR_BITS-1:0]  addr0,
   input  logic [ADDR_BITS-1:0]  addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic                  we0,
   input  logic                  we1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  busy,
   output logic                  grant_id
);
   localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
   logic [1:0] state, next_state;
   logic       grant, win, we_q;
   assign grant = (state == IDLE) && (req0 || req1);
`ifdef MEM_ARB_RR_EN
   logic last_grant;
   assign win = (req0 && req1) ? ~last_grant : ~req0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) last_grant <= 1'b1;
      else if (grant) last_grant <= win;
`else
   assign win = ~req0;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= next_state;
   always_comb
      next_state = (state == IDLE) ? ((req0 || req1) ? ACCESS : IDLE) :
                   (state == ACCESS) ? RESP : IDLE;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mem_addr    <= '0;
         mem_data_in <= '0;
         we_q        <= 1'b0;
         grant_id    <= 1'b0;
      end else if (grant) begin
         mem_addr    <= win ? addr1 : addr0;
         mem_data_in <= win ? wdata1 : wdata0;
         we_q        <= win ? we1 : we0;
         grant_id    <= win;
      end
   // write strobe is gated by state so an async reset kills it mid-access
   always_comb begin
      busy    = (state == ACCESS) || (state == RESP);
      mem_wen = (state == ACCESS) && we_q;
      ack0    = (state == RESP) && !grant_id;
      ack1    = (state == RESP) && grant_id;
      rdata0  = ack0 ? mem_data_out : '0;
      rdata1  = ack1 ? mem_data_out : '0;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a 1-cycle-latency memory model.
module tb_mem_arbiter;
   logic       clk = 0, rst = 1;
   logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [4:0] addr0 = 0, addr1 = 0;
   logic [7:0] wdata0 = 0, wdata1 = 0;
   logic       ack0, ack1, mem_wen, busy, grant_id;
   logic [7:0] rdata0, rdata1, mem_data_in, mem_data_out = 0;
   logic [4:0] mem_addr;
   logic [7:0] mem [32];
   int         n_cmp = 0, n_err = 0;

   mem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1), .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_wen(mem_wen), .mem_data_out(mem_data_out), .busy(busy), .grant_id(grant_id));

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_wen) begin
         mem[mem_addr] <= mem_data_in;
         mem_data_out  <= 8'd0;
      end else mem_data_out <= mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
      #1 rst = 0;
      #1;
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data_in, 0);
      check("rst_wen", mem_wen, 0);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_busy", busy, 0);
      check("rst_gid", grant_id, 0);
      step();
      step();
      rst = 1;
      // write 42 to addr 5 from requester 0
      req0 = 1; we0 = 1; addr0 = 5; wdata0 = 8'd42;
      step();
      check("w_wen", mem_wen, 1);
      check("w_addr", mem_addr, 5);
      check("w_data", mem_data_in, 42);
      check("w_busy", busy, 1);
      check("w_ack0_acc", ack0, 0);
      check("w_gid", grant_id, 0);
      step();
      check("w_ack0", ack0, 1);
      check("w_ack1", ack1, 0);
      check("w_wen_resp", mem_wen, 0);
      req0 = 0; we0 = 0;
      step();
      check("w_ack0_idle", ack0, 0);
      check("w_busy_idle", busy, 0);
      check("w_addr_hold", mem_addr, 5);
      // read back through requester 1
      req1 = 1; we1 = 0; addr1 = 5;
      step();
      check("r_gid", grant_id, 1);
      check("r_wen", mem_wen, 0);
      check("r_rdata0_acc", rdata0, 0);
      step();
      check("r_ack1", ack1, 1);
      check("r_ack0", ack0, 0);
      check("r_rdata1", rdata1, 42);
      check("r_rdata0", rdata0, 0);
      req1 = 0;
      step();
      check("r_ack1_idle", ack1, 0);
      // contention, both held for 12 cycles
      req0 = 1; req1 = 1; addr0 = 1; addr1 = 2;
      for (int s = 1; s <= 12; s++) begin
         step();
         if (s % 3 == 2) begin
`ifdef MEM_ARB_RR_EN
            w = ((s - 2) / 3) % 2;
`else
            w = 0;
`endif
            check("c_ack0", ack0, w == 0);
            check("c_ack1", ack1, w == 1);
            check("c_rdata", w ? rdata1 : rdata0, w ? 8'hA2 : 8'hA1);
         end else begin
            check("c_ack0_off", ack0, 0);
            check("c_ack1_off", ack1, 0);
         end
      end
      req0 = 0; req1 = 0;
      step();
      // read addr 7 with req dropped during ACCESS
      req0 = 1; we0 = 0; addr0 = 7;
      step();
      req0 = 0; addr0 = 0;
      check("d_busy", busy, 1);
      step();
      check("d_ack0", ack0, 1);
      check("d_rdata0", rdata0, 8'hA7);
      step();
      check("d_ack0_idle", ack0, 0);
      check("d_busy_idle", busy, 0);
      step();
      check("d_ack0_none", ack0, 0);
      // async reset during a write of 99 to addr 3
      req0 = 1; we0 = 1; addr0 = 3; wdata0 = 8'd99;
      step();
      check("a_wen", mem_wen, 1);
      req0 = 0; we0 = 0;
      @(negedge clk);
      rst = 0;
      #1;
      check("a_wen_drop", mem_wen, 0);
      check("a_busy", busy, 0);
      check("a_addr", mem_addr, 0);
      #3 rst = 1;
      step();
      check("a_ack0_1", ack0, 0);
      check("a_busy_1", busy, 0);
      step();
      check("a_ack0_2", ack0, 0);
      req0 = 1; addr0 = 3;
      step();
      step();
      check("a_ack0_rd", ack0, 1);
      check("a_rdata0", rdata0, 8'hA3);
      req0 = 0;
      step();
      // illegal state recovery
      @(negedge clk);
      force dut.state = 2'b11;
      #1;
      check("x_busy", busy, 0);
      check("x_ack0", ack0, 0);
      check("x_ack1", ack1, 0);
      check("x_wen", mem_wen, 0);
      release dut.state;
      step();
      check("x_state", dut.state, 0);
      check("x_ack0_after", ack0, 0);
      check("x_wen_after", mem_wen, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
